// File: rtl/u3v_format_pkg.sv
// Shared types and reset defaults for the U3V format sequencer.
// The chunk states exist only when U3V_CHUNK_EN is defined.
package u3v_format_pkg;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_PRE_LEADER  = 4'd1,
        ST_LEADER      = 4'd2,
        ST_IMAGE       = 4'd3,
`ifdef U3V_CHUNK_EN
        ST_CHUNK_GAP   = 4'd4,
        ST_CHUNK       = 4'd5,
`endif
        ST_TRAILER_GAP = 4'd6,
        ST_TRAILER     = 4'd7,
        ST_TAIL        = 4'd8
    } state_e;

    localparam int LEADER_PRE  = 32'd10;
    localparam int LEADER_LEN  = 32'd13;
    localparam int CHUNK_GAP   = 32'd1;
    localparam int CHUNK_LEN   = 32'd10;
    localparam int TRAILER_GAP = 32'd9;
    localparam int TRAILER_LEN = 32'd12;
    localparam int FVAL_TAIL   = 32'd9;

    localparam logic [63:0] BLOCKID_INIT = {64{1'b1}};

endpackage

// File: rtl/u3v_format_sequencer_timer.sv
// Phase timer: counts down the cycles of the current phase; done marks the last cycle.
// A counter sitting at zero also reports done so a zero load can never stall the sequencer.
module u3v_phase_timer #(
    parameter int CNT_WD = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [CNT_WD-1:0] load_len,
    output logic              done
);

    localparam logic [CNT_WD-1:0] CNT_ZERO = {CNT_WD{1'b0}};
    localparam logic [CNT_WD-1:0] CNT_ONE  = {{(CNT_WD-1){1'b0}}, 1'b1};

    logic [CNT_WD-1:0] cnt_r;

    // Down-counter reloaded on every phase entry
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= CNT_ZERO;
        end else if (load) begin
            cnt_r <= load_len;
        end else if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r <= CNT_ONE);

endmodule

// File: rtl/u3v_format_sequencer.sv
// U3V format sequencer: programmable leader/image/chunk/trailer phasing, stream merge and block ID.
// Optional chunk phase is built only when U3V_CHUNK_EN is defined.
module u3v_format_sequencer
    import u3v_format_pkg::*;
#(
    parameter int DATA_WD     = 32,
    parameter int CNT_WD      = 8,
    parameter int LONG_REG_WD = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_fval,
    input  logic                   i_stream_enable,
`ifdef U3V_CHUNK_EN
    input  logic                   i_chunk_mode_active,
    input  logic [CNT_WD-1:0]      iv_chunk_gap,
    input  logic [CNT_WD-1:0]      iv_chunk_len,
`endif
    input  logic [CNT_WD-1:0]      iv_leader_pre,
    input  logic [CNT_WD-1:0]      iv_leader_len,
    input  logic [CNT_WD-1:0]      iv_trailer_gap,
    input  logic [CNT_WD-1:0]      iv_trailer_len,
    input  logic [CNT_WD-1:0]      iv_fval_tail,
    input  logic                   i_leader_valid,
    input  logic [DATA_WD-1:0]     iv_leader_data,
    input  logic                   i_payload_valid,
    input  logic [DATA_WD-1:0]     iv_payload_data,
    input  logic                   i_trailer_valid,
    input  logic [DATA_WD-1:0]     iv_trailer_data,
    output logic                   o_leader_flag,
    output logic                   o_image_flag,
    output logic                   o_chunk_flag,
    output logic                   o_trailer_flag,
    output logic                   o_fval,
    output logic                   o_frame_overrun,
    output logic [LONG_REG_WD-1:0] ov_blockid,
    output logic                   o_data_valid,
    output logic [DATA_WD-1:0]     ov_data
);

    localparam logic [CNT_WD-1:0]      CNT_ZERO = {CNT_WD{1'b0}};
    localparam logic [CNT_WD-1:0]      CNT_ONE  = {{(CNT_WD-1){1'b0}}, 1'b1};
    localparam logic [LONG_REG_WD-1:0] ID_INIT  = LONG_REG_WD'(BLOCKID_INIT);
    localparam logic [LONG_REG_WD-1:0] ID_ONE   = {{(LONG_REG_WD-1){1'b0}}, 1'b1};

    state_e state_r, state_next_s;
    state_e post_trl_s, post_chunk_s, post_image_s, post_leader_s;

    logic fval_d_r, rise_s, fall_s, idle_s, accept_s;
    logic fall_seen_r, early_fall_s, timer_done_s, timer_load_s;
    logic [CNT_WD-1:0] load_len_s;

    logic [CNT_WD-1:0] pre_r, lead_r, tgap_r, tlen_r, tail_r;
    logic [CNT_WD-1:0] pre_s, lead_s, tgap_s, tlen_s, tail_s;
    logic [CNT_WD-1:0] lead_eff_s, tlen_eff_s;
`ifdef U3V_CHUNK_EN
    logic [CNT_WD-1:0] cgap_r, clen_r, cgap_s, clen_s;
    logic              chunk_act_r, chunk_act_s, chunk_on_s, chunk_flag_r;
`endif

    logic leader_flag_r, image_flag_r, trailer_flag_r, fval_r, overrun_r;
    logic trailer_d1_r, data_valid_r;
    logic [LONG_REG_WD-1:0] blockid_r;
    logic [DATA_WD-1:0]     data_mux_s, data_r;

    assign rise_s       = i_fval & ~fval_d_r;
    assign fall_s       = ~i_fval & fval_d_r;
    assign idle_s       = (state_r == ST_IDLE);
    assign accept_s     = rise_s & idle_s;
    assign early_fall_s = fall_seen_r | fall_s;

    // While idle the live register inputs govern the first phase; afterwards the captured copy does.
    assign pre_s  = idle_s ? iv_leader_pre  : pre_r;
    assign lead_s = idle_s ? iv_leader_len  : lead_r;
    assign tgap_s = idle_s ? iv_trailer_gap : tgap_r;
    assign tlen_s = idle_s ? iv_trailer_len : tlen_r;
    assign tail_s = idle_s ? iv_fval_tail   : tail_r;
`ifdef U3V_CHUNK_EN
    assign cgap_s      = idle_s ? iv_chunk_gap        : cgap_r;
    assign clen_s      = idle_s ? iv_chunk_len        : clen_r;
    assign chunk_act_s = idle_s ? i_chunk_mode_active : chunk_act_r;
`endif
    assign lead_eff_s = (lead_s == CNT_ZERO) ? CNT_ONE : lead_s;
    assign tlen_eff_s = (tlen_s == CNT_ZERO) ? CNT_ONE : tlen_s;

    // Edge-detect history; held high through reset so a frame cut by reset is not restarted
    always_ff @(posedge clk) begin
        if (reset) begin
            fval_d_r <= 1'b1;
        end else begin
            fval_d_r <= i_fval;
        end
    end

    // Frame configuration is captured once, when a frame is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_r  <= CNT_WD'(LEADER_PRE);
            lead_r <= CNT_WD'(LEADER_LEN);
            tgap_r <= CNT_WD'(TRAILER_GAP);
            tlen_r <= CNT_WD'(TRAILER_LEN);
            tail_r <= CNT_WD'(FVAL_TAIL);
`ifdef U3V_CHUNK_EN
            cgap_r      <= CNT_WD'(CHUNK_GAP);
            clen_r      <= CNT_WD'(CHUNK_LEN);
            chunk_act_r <= 1'b0;
`endif
        end else if (accept_s) begin
            pre_r  <= iv_leader_pre;
            lead_r <= iv_leader_len;
            tgap_r <= iv_trailer_gap;
            tlen_r <= iv_trailer_len;
            tail_r <= iv_fval_tail;
`ifdef U3V_CHUNK_EN
            cgap_r      <= iv_chunk_gap;
            clen_r      <= iv_chunk_len;
            chunk_act_r <= i_chunk_mode_active;
`endif
        end else begin
            pre_r  <= pre_r;
            lead_r <= lead_r;
            tgap_r <= tgap_r;
            tlen_r <= tlen_r;
            tail_r <= tail_r;
`ifdef U3V_CHUNK_EN
            cgap_r      <= cgap_r;
            clen_r      <= clen_r;
            chunk_act_r <= chunk_act_r;
`endif
        end
    end

    // Remembers an fval fall that arrived before the image phase could start
    always_ff @(posedge clk) begin
        if (reset) begin
            fall_seen_r <= 1'b0;
        end else if (idle_s) begin
            fall_seen_r <= 1'b0;
        end else if (fall_s && ((state_r == ST_PRE_LEADER) || (state_r == ST_LEADER))) begin
            fall_seen_r <= 1'b1;
        end else begin
            fall_seen_r <= fall_seen_r;
        end
    end

    // Next-state logic; zero-length phases are folded into the successor chain
    always_comb begin
        post_trl_s   = (tail_s != CNT_ZERO) ? ST_TAIL : ST_IDLE;
        post_chunk_s = (tgap_s != CNT_ZERO) ? ST_TRAILER_GAP : ST_TRAILER;
`ifdef U3V_CHUNK_EN
        chunk_on_s   = chunk_act_s & (clen_s != CNT_ZERO);
        if (chunk_on_s) begin
            post_image_s = (cgap_s != CNT_ZERO) ? ST_CHUNK_GAP : ST_CHUNK;
        end else begin
            post_image_s = post_chunk_s;
        end
`else
        post_image_s = post_chunk_s;
`endif
        post_leader_s = early_fall_s ? post_image_s : ST_IMAGE;
        state_next_s  = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    state_next_s = (pre_s != CNT_ZERO) ? ST_PRE_LEADER : ST_LEADER;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PRE_LEADER:  state_next_s = timer_done_s ? ST_LEADER : state_r;
            ST_LEADER:      state_next_s = timer_done_s ? post_leader_s : state_r;
            ST_IMAGE:       state_next_s = fall_s ? post_image_s : state_r;
`ifdef U3V_CHUNK_EN
            ST_CHUNK_GAP:   state_next_s = timer_done_s ? ST_CHUNK : state_r;
            ST_CHUNK:       state_next_s = timer_done_s ? post_chunk_s : state_r;
`endif
            ST_TRAILER_GAP: state_next_s = timer_done_s ? ST_TRAILER : state_r;
            ST_TRAILER:     state_next_s = timer_done_s ? post_trl_s : state_r;
            ST_TAIL:        state_next_s = timer_done_s ? ST_IDLE : state_r;
            default:        state_next_s = ST_IDLE;
        endcase
    end

    // Length loaded into the timer for the phase being entered
    always_comb begin
        load_len_s = CNT_ZERO;
        case (state_next_s)
            ST_PRE_LEADER:  load_len_s = pre_s;
            ST_LEADER:      load_len_s = lead_eff_s;
`ifdef U3V_CHUNK_EN
            ST_CHUNK_GAP:   load_len_s = cgap_s;
            ST_CHUNK:       load_len_s = clen_s;
`endif
            ST_TRAILER_GAP: load_len_s = tgap_s;
            ST_TRAILER:     load_len_s = tlen_eff_s;
            ST_TAIL:        load_len_s = tail_s;
            default:        load_len_s = CNT_ZERO;
        endcase
    end

    assign timer_load_s = (state_next_s != state_r);

    u3v_phase_timer #(
        .CNT_WD   (CNT_WD)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load_s),
        .load_len (load_len_s),
        .done     (timer_done_s)
    );

    // State register plus flags decoded from the next state, so flags match the registered state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            leader_flag_r  <= 1'b0;
            image_flag_r   <= 1'b0;
            trailer_flag_r <= 1'b0;
            fval_r         <= 1'b0;
            overrun_r      <= 1'b0;
            trailer_d1_r   <= 1'b0;
`ifdef U3V_CHUNK_EN
            chunk_flag_r   <= 1'b0;
`endif
        end else begin
            state_r        <= state_next_s;
            leader_flag_r  <= (state_next_s == ST_LEADER);
            image_flag_r   <= (state_next_s == ST_IMAGE);
            trailer_flag_r <= (state_next_s == ST_TRAILER);
            fval_r         <= (state_next_s != ST_IDLE);
            overrun_r      <= rise_s & ~idle_s;
            trailer_d1_r   <= trailer_flag_r;
`ifdef U3V_CHUNK_EN
            chunk_flag_r   <= (state_next_s == ST_CHUNK);
`endif
        end
    end

    // Block ID: parked at all-ones while the stream is disabled, bumped per accepted frame
    always_ff @(posedge clk) begin
        if (reset || !i_stream_enable) begin
            blockid_r <= ID_INIT;
        end else if (accept_s) begin
            blockid_r <= blockid_r + ID_ONE;
        end else begin
            blockid_r <= blockid_r;
        end
    end

    // Source priority: leader, then payload, then trailer
    always_comb begin
        if (i_leader_valid) begin
            data_mux_s = iv_leader_data;
        end else if (i_payload_valid) begin
            data_mux_s = iv_payload_data;
        end else if (i_trailer_valid) begin
            data_mux_s = iv_trailer_data;
        end else begin
            data_mux_s = {DATA_WD{1'b0}};
        end
    end

    // Merged stream register; trailer words are qualified by the delayed trailer flag
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r       <= {DATA_WD{1'b0}};
            data_valid_r <= 1'b0;
        end else begin
            data_r       <= data_mux_s;
            data_valid_r <= i_leader_valid | i_payload_valid | trailer_d1_r;
        end
    end

    assign o_leader_flag   = leader_flag_r;
    assign o_image_flag    = image_flag_r;
    assign o_trailer_flag  = trailer_flag_r;
`ifdef U3V_CHUNK_EN
    assign o_chunk_flag    = chunk_flag_r;
`else
    assign o_chunk_flag    = 1'b0;
`endif
    assign o_fval          = fval_r;
    assign o_frame_overrun = overrun_r;
    assign ov_blockid      = blockid_r;
    assign o_data_valid    = data_valid_r;
    assign ov_data         = data_r;

endmodule
